// File: rtl/fb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_pkg : shared framebuffer geometry, fill-FSM states and address helper
// Rev 1.0
// ---------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_W    = 160;
    localparam int FB_H    = 120;
    localparam int ADDR_W  = 15;
    localparam int COLOR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLIP = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } fb_state_e;

    function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
        return ADDR_W'(y) * ADDR_W'(FB_W) + ADDR_W'(x);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_fill_scheduler_rect_walker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rect_walker : raster-order position tracker for a clipped fill rectangle
// Rev 1.0
// ---------------------------------------------------------------------------
module rect_walker
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic [7:0]        i_x0,
    input  logic [6:0]        i_y0,
    input  logic [8:0]        i_x_end,
    input  logic [8:0]        i_y_end,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [7:0]        r_x0;
    logic [7:0]        r_cx;
    logic [6:0]        r_cy;
    logic [7:0]        r_x_last;
    logic [6:0]        r_y_last;
    logic [ADDR_W-1:0] r_row_base;
    logic              w_row_end;

    assign w_row_end = (r_cx == r_x_last);
    assign o_last    = w_row_end && (r_cy == r_y_last);
    assign o_addr    = r_row_base + ADDR_W'(r_cx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x0       <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_x_last   <= '0;
            r_y_last   <= '0;
            r_row_base <= '0;
        end else if (i_load) begin
            // Inclusive end coordinates keep the per-pixel compare narrow.
            r_x0       <= i_x0;
            r_cx       <= i_x0;
            r_cy       <= i_y0;
            r_x_last   <= 8'(i_x_end - 9'd1);
            r_y_last   <= 7'(i_y_end - 9'd1);
            r_row_base <= fb_addr(8'd0, i_y0);
        end else if (i_advance) begin
            if (w_row_end) begin
                r_cx       <= r_x0;
                r_cy       <= r_cy + 7'd1;
                r_row_base <= r_row_base + ADDR_W'(FB_W);
            end else begin
                r_cx       <= r_cx + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_fill_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_fill_scheduler : rectangle-fill sequencer sharing the framebuffer port
// with video reads (video always wins). Option: FB_FILL_VBLANK_GATE_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module fb_fill_scheduler
    import fb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [7:0]         cmd_x0,
    input  logic [6:0]         cmd_y0,
    input  logic [7:0]         cmd_w,
    input  logic [6:0]         cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               vid_req,
    input  logic [ADDR_W-1:0]  vid_addr,
    output logic [COLOR_W-1:0] vid_data,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic [COLOR_W-1:0] mem_rdata,
`ifdef FB_FILL_VBLANK_GATE_EN
    input  logic               vblank,
`endif
    output logic               busy,
    output logic               done
);

    fb_state_e          r_state;
    fb_state_e          w_next;
    logic [7:0]         r_x0;
    logic [6:0]         r_y0;
    logic [7:0]         r_w;
    logic [6:0]         r_h;
    logic [COLOR_W-1:0] r_color;

    logic [8:0]         w_x_sum;
    logic [8:0]         w_y_sum;
    logic [8:0]         w_x_end;
    logic [8:0]         w_y_end;
    logic               w_empty;
    logic               w_gate;
    logic               w_write;
    logic               w_accept;
    logic               w_last;
    logic [ADDR_W-1:0]  w_fill_addr;

    assign w_accept = cmd_valid && (r_state == ST_IDLE);

    // 9-bit sums cannot wrap, so clipping is a plain min().
    assign w_x_sum = {1'b0, r_x0} + {1'b0, r_w};
    assign w_y_sum = {2'b00, r_y0} + {2'b00, r_h};
    assign w_x_end = (w_x_sum > 9'(FB_W)) ? 9'(FB_W) : w_x_sum;
    assign w_y_end = (w_y_sum > 9'(FB_H)) ? 9'(FB_H) : w_y_sum;
    assign w_empty = (r_w == 8'd0) || (r_h == 7'd0) ||
                     ({1'b0, r_x0} >= 9'(FB_W)) || ({2'b00, r_y0} >= 9'(FB_H));

`ifdef FB_FILL_VBLANK_GATE_EN
    assign w_gate = vblank;
`else
    assign w_gate = 1'b1;
`endif

    assign w_write = (r_state == ST_FILL) && !vid_req && w_gate;

    rect_walker u_walker (
        .clk       (clk),
        .rst       (rst),
        .i_load    (r_state == ST_CLIP),
        .i_advance (w_write),
        .i_x0      (r_x0),
        .i_y0      (r_y0),
        .i_x_end   (w_x_end),
        .i_y_end   (w_y_end),
        .o_addr    (w_fill_addr),
        .o_last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_x0    <= '0;
            r_y0    <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_color <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_x0    <= cmd_x0;
                r_y0    <= cmd_y0;
                r_w     <= cmd_w;
                r_h     <= cmd_h;
                r_color <= cmd_color;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_CLIP;
            ST_CLIP: w_next = w_empty ? ST_DONE : ST_FILL;
            ST_FILL: if (w_write && w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign busy      = (r_state != ST_IDLE);
    assign cmd_ready = (r_state == ST_IDLE);
    assign done      = (r_state == ST_DONE);

    assign mem_addr  = vid_req ? vid_addr : w_fill_addr;
    assign mem_we    = w_write;
    assign mem_wdata = r_color;
    assign vid_data  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_fb_fill_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fb_fill_scheduler : randomized check of fb_fill_scheduler against a
// pixel-list reference model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_fb_fill_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x0;
    logic [6:0]  cmd_y0;
    logic [7:0]  cmd_w;
    logic [6:0]  cmd_h;
    logic [2:0]  cmd_color;
    logic        vid_req;
    logic [14:0] vid_addr;
    logic [2:0]  vid_data;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [2:0]  mem_wdata;
    logic [2:0]  mem_rdata;
    logic        busy;
    logic        done;
    logic        vblank;

    always #20 clk = ~clk;

    fb_fill_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
`ifdef FB_FILL_VBLANK_GATE_EN
        .vblank    (vblank),
`endif
        .busy      (busy),
        .done      (done)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: phase 0 idle, 1 clipping, 2 writing, 3 completion pulse.
    int m_phase = 0;
    int m_color = 0;
    int m_popped = 0;
    int exp_q[$];
    int obs_q[$];
    bit acc_now;
    int g_rel = 0;
    int done_rel = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void build_pixels(input int x0, input int y0, input int w, input int h);
        exp_q.delete();
        if (w > 0 && h > 0 && x0 < 160 && y0 < 120)
            for (int y = y0; y < y0 + h && y < 120; y++)
                for (int x = x0; x < x0 + w && x < 160; x++)
                    exp_q.push_back(y * 160 + x);
    endfunction

    task automatic tick(input bit vreq);
        bit exp_we;
        vid_req   = vreq;
        vid_addr  = 15'($urandom_range(0, 19199));
        mem_rdata = 3'($urandom);
`ifdef FB_FILL_VBLANK_GATE_EN
        vblank    = ($urandom_range(0, 3) != 0);
`else
        vblank    = 1'b1;
`endif
        @(negedge clk);
        exp_we = (m_phase == 2) && !vreq && vblank;
        check_eq("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0));
        check_eq("busy",      32'(busy),      32'(m_phase != 0));
        check_eq("done",      32'(done),      32'(m_phase == 3));
        check_eq("mem_we",    32'(mem_we),    32'(exp_we));
        check_eq("vid_data",  32'(vid_data),  32'(mem_rdata));
        if (vreq)
            check_eq("mem_addr_vid", 32'(mem_addr), 32'(vid_addr));
        else if (exp_we) begin
            check_eq("mem_addr_fill", 32'(mem_addr), 32'(exp_q[0]));
            check_eq("mem_wdata",     32'(mem_wdata), 32'(m_color));
        end
        if (mem_we === 1'b1) obs_q.push_back(int'(mem_addr));
        if (done === 1'b1) done_rel = g_rel;

        acc_now = 1'b0;
        if (rst) begin
            m_phase = 0;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: if (cmd_valid) begin
                    build_pixels(int'(cmd_x0), int'(cmd_y0), int'(cmd_w), int'(cmd_h));
                    m_color  = int'(cmd_color);
                    m_popped = 0;
                    m_phase  = 1;
                    acc_now  = 1'b1;
                end
                1: m_phase = (exp_q.size() == 0) ? 3 : 2;
                2: if (exp_we) begin
                    void'(exp_q.pop_front());
                    m_popped++;
                    if (exp_q.size() == 0) m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    // vmode: 0 no video, 1 random video, 2 video on cycles N+3..N+5.
    task automatic run_cmd(input int x0, input int y0, input int w, input int h, input int c,
                           input int vmode, input int rst_at, input bit overlap);
        bit accepted = 1'b0;
        bit fin = 1'b0;
        bit vr;
        obs_q.delete();
        done_rel  = -1;
        cmd_valid = 1'b1;
        cmd_x0    = 8'(x0);
        cmd_y0    = 7'(y0);
        cmd_w     = 8'(w);
        cmd_h     = 7'(h);
        cmd_color = 3'(c);
        for (int k = 0; k < 3000; k++) begin
            rst = 1'b0;
            if (accepted) g_rel++;
            if (vmode == 1) vr = ($urandom_range(0, 3) == 0);
            else            vr = (vmode == 2) && accepted && g_rel >= 3 && g_rel <= 5;
            if (rst_at > 0 && m_phase == 2 && m_popped == rst_at - 1) begin
                rst = 1'b1;
                vr  = 1'b0;
            end
            tick(vr);
            if (acc_now) begin
                accepted  = 1'b1;
                g_rel     = 0;
                cmd_valid = 1'b0;
                cmd_x0    = 8'($urandom);
                cmd_w     = 8'($urandom);
            end
            if (accepted && (m_phase == 0 || (overlap && m_phase == 3))) begin
                fin = 1'b1;
                break;
            end
        end
        if (!fin) check_eq("timeout", 32'd0, 32'd1);
    endtask

    int exp1 [6] = '{810, 811, 812, 970, 971, 972};

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0;
        cmd_color = '0; vid_req = 1'b0; vid_addr = '0; mem_rdata = '0; vblank = 1'b1;
        @(posedge clk); #1;
        tick(1'b0);
        tick(1'b1);
        rst = 1'b0;

        run_cmd(10, 5, 3, 2, 5, 0, 0, 1'b0);
        check_eq("t1_count", 32'(obs_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) check_eq($sformatf("t1_addr%0d", i), 32'(obs_q[i]), 32'(exp1[i]));
        check_eq("t1_done_rel", 32'(done_rel), 32'd8);

        run_cmd(10, 5, 3, 2, 5, 2, 0, 1'b0);
        check_eq("t2_count", 32'(obs_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) check_eq($sformatf("t2_addr%0d", i), 32'(obs_q[i]), 32'(exp1[i]));
        check_eq("t2_done_rel", 32'(done_rel), 32'd11);

        run_cmd(158, 119, 5, 4, 2, 1, 0, 1'b0);
        check_eq("clip_count", 32'(obs_q.size()), 32'd2);
        check_eq("clip_addr0", 32'(obs_q[0]), 32'd19198);
        check_eq("clip_addr1", 32'(obs_q[1]), 32'd19199);

        run_cmd(200, 3, 4, 4, 1, 0, 0, 1'b0);
        check_eq("offscreen_count", 32'(obs_q.size()), 32'd0);
        check_eq("offscreen_done_rel", 32'(done_rel), 32'd2);
        run_cmd(4, 4, 0, 3, 1, 0, 0, 1'b0);
        check_eq("w0_done_rel", 32'(done_rel), 32'd2);
        run_cmd(4, 4, 3, 0, 1, 0, 0, 1'b0);
        check_eq("h0_done_rel", 32'(done_rel), 32'd2);

        run_cmd(20, 30, 4, 4, 6, 0, 3, 1'b0);
        check_eq("abort_count", 32'(obs_q.size()), 32'd3);
        check_eq("abort_no_done", 32'(done_rel), 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) tick(1'b0);
        check_eq("abort_no_done_after", 32'(done_rel), 32'hFFFF_FFFF);
        run_cmd(20, 30, 4, 4, 6, 1, 0, 1'b0);
        check_eq("fresh_count", 32'(obs_q.size()), 32'd16);

        for (int i = 0; i < 40; i++) begin
            int w;
            w = (i % 5 == 4) ? 0 : int'($urandom_range(1, 14));
            run_cmd(int'($urandom_range(0, 200)), int'($urandom_range(0, 127)), w,
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 7)), 1, 0, bit'(i % 2));
        end
        for (int i = 0; i < 4; i++) tick(bit'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
